// File: rtl/axi4_arbiter_2to1_if.sv
// ifc_axi4: full AXI4 bundle with master/slave views, shared by the arbiter and its neighbours.
interface ifc_axi4 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int USER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic [3:0]              awregion;
    logic [USER_WIDTH-1:0]   awuser;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic [USER_WIDTH-1:0]   wuser;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic [USER_WIDTH-1:0]   buser;
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic [3:0]              arregion;
    logic [USER_WIDTH-1:0]   aruser;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic [USER_WIDTH-1:0]   ruser;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wuser, wvalid,
        input  wready,
        input  bid, bresp, buser, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, ruser, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wuser, wvalid,
        output wready,
        output bid, bresp, buser, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, ruser, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi4_arbiter_2to1.sv
// axi4_arbiter_2to1: two AXI4 masters share one downstream port; independent round-robin
// write and read paths, one outstanding transaction per path.
module axi4_arbiter_2to1 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int USER_WIDTH = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    ifc_axi4.slave  s0_axi,
    ifc_axi4.slave  s1_axi,
    ifc_axi4.master m_axi,
    output logic    wr_busy,
    output logic    rd_busy,
    output logic    wr_grant,
    output logic    rd_grant
);
    if (DATA_WIDTH < 8 || DATA_WIDTH > 1024 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0 ||
        ADDR_WIDTH < 1 || ID_WIDTH < 1 || USER_WIDTH < 1) begin : g_bad_params
        $error("axi4_arbiter_2to1: illegal parameter set");
    end

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;
    logic     wr_grant_q, wr_grant_d, rd_grant_q, rd_grant_d;
    logic     aw0, aw1, w0, w1, b0, b1, ar0, ar1, r0, r1;

    // grant registers reset to 1 so port 0 wins the first contention
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            wr_grant_q <= 1'b1;
            rd_grant_q <= 1'b1;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            wr_grant_q <= wr_grant_d;
            rd_grant_q <= rd_grant_d;
        end
    end

    always_comb begin
        w_state_d  = w_state_q;
        wr_grant_d = wr_grant_q;
        case (w_state_q)
            W_IDLE: if (s0_axi.awvalid || s1_axi.awvalid) begin
                w_state_d  = W_ADDR;
                wr_grant_d = (s0_axi.awvalid && s1_axi.awvalid) ? ~wr_grant_q : s1_axi.awvalid;
            end
            W_ADDR:  if (m_axi.awvalid && m_axi.awready) w_state_d = W_DATA;
            W_DATA:  if (m_axi.wvalid && m_axi.wready && m_axi.wlast) w_state_d = W_RESP;
            W_RESP:  if (m_axi.bvalid && m_axi.bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d  = r_state_q;
        rd_grant_d = rd_grant_q;
        case (r_state_q)
            R_IDLE: if (s0_axi.arvalid || s1_axi.arvalid) begin
                r_state_d  = R_ADDR;
                rd_grant_d = (s0_axi.arvalid && s1_axi.arvalid) ? ~rd_grant_q : s1_axi.arvalid;
            end
            R_ADDR:  if (m_axi.arvalid && m_axi.arready) r_state_d = R_DATA;
            R_DATA:  if (m_axi.rvalid && m_axi.rready && m_axi.rlast) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // per-channel, per-port enables decoded from registered state only
    assign aw0 = w_state_q == W_ADDR && !wr_grant_q;
    assign aw1 = w_state_q == W_ADDR &&  wr_grant_q;
    assign w0  = w_state_q == W_DATA && !wr_grant_q;
    assign w1  = w_state_q == W_DATA &&  wr_grant_q;
    assign b0  = w_state_q == W_RESP && !wr_grant_q;
    assign b1  = w_state_q == W_RESP &&  wr_grant_q;
    assign ar0 = r_state_q == R_ADDR && !rd_grant_q;
    assign ar1 = r_state_q == R_ADDR &&  rd_grant_q;
    assign r0  = r_state_q == R_DATA && !rd_grant_q;
    assign r1  = r_state_q == R_DATA &&  rd_grant_q;

    always_comb begin
        m_axi.awid     = aw1 ? s1_axi.awid     : aw0 ? s0_axi.awid     : '0;
        m_axi.awaddr   = aw1 ? s1_axi.awaddr   : aw0 ? s0_axi.awaddr   : '0;
        m_axi.awlen    = aw1 ? s1_axi.awlen    : aw0 ? s0_axi.awlen    : '0;
        m_axi.awsize   = aw1 ? s1_axi.awsize   : aw0 ? s0_axi.awsize   : '0;
        m_axi.awburst  = aw1 ? s1_axi.awburst  : aw0 ? s0_axi.awburst  : '0;
        m_axi.awlock   = aw1 ? s1_axi.awlock   : aw0 ? s0_axi.awlock   : '0;
        m_axi.awcache  = aw1 ? s1_axi.awcache  : aw0 ? s0_axi.awcache  : '0;
        m_axi.awprot   = aw1 ? s1_axi.awprot   : aw0 ? s0_axi.awprot   : '0;
        m_axi.awqos    = aw1 ? s1_axi.awqos    : aw0 ? s0_axi.awqos    : '0;
        m_axi.awregion = aw1 ? s1_axi.awregion : aw0 ? s0_axi.awregion : '0;
        m_axi.awuser   = aw1 ? s1_axi.awuser   : aw0 ? s0_axi.awuser   : '0;
        m_axi.awvalid  = aw1 ? s1_axi.awvalid  : aw0 ? s0_axi.awvalid  : '0;
        m_axi.wdata    = w1  ? s1_axi.wdata    : w0  ? s0_axi.wdata    : '0;
        m_axi.wstrb    = w1  ? s1_axi.wstrb    : w0  ? s0_axi.wstrb    : '0;
        m_axi.wlast    = w1  ? s1_axi.wlast    : w0  ? s0_axi.wlast    : '0;
        m_axi.wuser    = w1  ? s1_axi.wuser    : w0  ? s0_axi.wuser    : '0;
        m_axi.wvalid   = w1  ? s1_axi.wvalid   : w0  ? s0_axi.wvalid   : '0;
        m_axi.bready   = b1  ? s1_axi.bready   : b0  ? s0_axi.bready   : '0;
        s0_axi.awready = aw0 && m_axi.awready;
        s1_axi.awready = aw1 && m_axi.awready;
        s0_axi.wready  = w0 && m_axi.wready;
        s1_axi.wready  = w1 && m_axi.wready;
        s0_axi.bid     = b0 ? m_axi.bid    : '0;
        s0_axi.bresp   = b0 ? m_axi.bresp  : '0;
        s0_axi.buser   = b0 ? m_axi.buser  : '0;
        s0_axi.bvalid  = b0 && m_axi.bvalid;
        s1_axi.bid     = b1 ? m_axi.bid    : '0;
        s1_axi.bresp   = b1 ? m_axi.bresp  : '0;
        s1_axi.buser   = b1 ? m_axi.buser  : '0;
        s1_axi.bvalid  = b1 && m_axi.bvalid;
        wr_busy        = w_state_q != W_IDLE;
        wr_grant       = wr_grant_q;
    end

    always_comb begin
        m_axi.arid     = ar1 ? s1_axi.arid     : ar0 ? s0_axi.arid     : '0;
        m_axi.araddr   = ar1 ? s1_axi.araddr   : ar0 ? s0_axi.araddr   : '0;
        m_axi.arlen    = ar1 ? s1_axi.arlen    : ar0 ? s0_axi.arlen    : '0;
        m_axi.arsize   = ar1 ? s1_axi.arsize   : ar0 ? s0_axi.arsize   : '0;
        m_axi.arburst  = ar1 ? s1_axi.arburst  : ar0 ? s0_axi.arburst  : '0;
        m_axi.arlock   = ar1 ? s1_axi.arlock   : ar0 ? s0_axi.arlock   : '0;
        m_axi.arcache  = ar1 ? s1_axi.arcache  : ar0 ? s0_axi.arcache  : '0;
        m_axi.arprot   = ar1 ? s1_axi.arprot   : ar0 ? s0_axi.arprot   : '0;
        m_axi.arqos    = ar1 ? s1_axi.arqos    : ar0 ? s0_axi.arqos    : '0;
        m_axi.arregion = ar1 ? s1_axi.arregion : ar0 ? s0_axi.arregion : '0;
        m_axi.aruser   = ar1 ? s1_axi.aruser   : ar0 ? s0_axi.aruser   : '0;
        m_axi.arvalid  = ar1 ? s1_axi.arvalid  : ar0 ? s0_axi.arvalid  : '0;
        m_axi.rready   = r1  ? s1_axi.rready   : r0  ? s0_axi.rready   : '0;
        s0_axi.arready = ar0 && m_axi.arready;
        s1_axi.arready = ar1 && m_axi.arready;
        s0_axi.rid     = r0 ? m_axi.rid   : '0;
        s0_axi.rdata   = r0 ? m_axi.rdata : '0;
        s0_axi.rresp   = r0 ? m_axi.rresp : '0;
        s0_axi.rlast   = r0 && m_axi.rlast;
        s0_axi.ruser   = r0 ? m_axi.ruser : '0;
        s0_axi.rvalid  = r0 && m_axi.rvalid;
        s1_axi.rid     = r1 ? m_axi.rid   : '0;
        s1_axi.rdata   = r1 ? m_axi.rdata : '0;
        s1_axi.rresp   = r1 ? m_axi.rresp : '0;
        s1_axi.rlast   = r1 && m_axi.rlast;
        s1_axi.ruser   = r1 ? m_axi.ruser : '0;
        s1_axi.rvalid  = r1 && m_axi.rvalid;
        rd_busy        = r_state_q != R_IDLE;
        rd_grant       = rd_grant_q;
    end
endmodule

// File: doc/axi4_arbiter_2to1.md
Name: axi4_arbiter_2to1

Overview:
- Shares one downstream AXI4 master port between two upstream AXI4 masters.
- Write and read paths are arbitrated independently, each with round-robin grant.
- Each path allows one outstanding transaction at a time.
- Sits between two DMA/accelerator masters and a single memory/interconnect port; all three ports are ifc_axi4 instances.

Parameters:
ADDR_WIDTH, 32, address width of all three ports
DATA_WIDTH, 32, data width of all three ports; must be one of 8..1024 power of two
ID_WIDTH, 1, ID width of all ports; IDs pass through unchanged (no ID extension, since only one transaction is outstanding)
USER_WIDTH, 1, user signal width; passed through unchanged

Ports:
clk  input  1  clock
rst_n  input  1  synchronous reset, active low
s0_axi  ifc_axi4.slave  -  upstream port 0 (requester 0)
s1_axi  ifc_axi4.slave  -  upstream port 1 (requester 1)
m_axi  ifc_axi4.master  -  shared downstream port
wr_busy  output  1  write path not idle
rd_busy  output  1  read path not idle
wr_grant  output  1  index of last/current write grant
rd_grant  output  1  index of last/current read grant

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset values:
  - All m_axi valids (awvalid, wvalid, arvalid) = 0; m_axi bready = rready = 0.
  - All slave readies (awready, wready, arready) = 0; slave bvalid = rvalid = 0.
  - wr_busy = rd_busy = 0.
  - wr_grant = rd_grant = 1, so port 0 wins the first contention.
  - FSMs go to IDLE.
- Write FSM: W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: sample s0.awvalid and s1.awvalid.
    - Only one asserted: grant that port.
    - Both asserted: grant the port != wr_grant.
    - Register the grant and go to W_ADDR. One cycle of latency from upstream awvalid to m_axi.awvalid.
  - W_ADDR: all AW fields of the granted port are muxed combinationally to m_axi; m_axi.awready is routed back to the granted port. On the AW handshake, go to W_DATA.
  - W_DATA: W fields are muxed from the granted port; wready is routed back. On a W handshake with wlast=1, go to W_RESP. Beat count is not checked; wlast alone terminates the burst.
  - W_RESP: m_axi bid/bresp/buser/bvalid are routed to the granted port; its bready goes to m_axi.bready. On the B handshake, go to W_IDLE.
  - wr_busy = 1 in every state except W_IDLE.
  - Upstream W presented before the AW handshake is stalled (wready=0); this is AXI-legal.
- Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
  - Same round-robin rule as the write FSM, using rd_grant.
  - R_ADDR: AR fields are muxed; on the AR handshake, go to R_DATA.
  - R_DATA: R fields are routed to the granted port; on an R handshake with rlast=1, go to R_IDLE.
  - rd_busy = 1 in every state except R_IDLE.
- Non-granted ports:
  - The non-granted port (and both ports while IDLE) sees ready=0 and valid=0 on every channel of that path.
  - m_axi outputs of an idle path are driven to 0 (valids and all payload fields).
- Independence: read and write paths may be granted to different ports or the same port concurrently; there is no interaction between them.
- Grant stability: the grant registers change only on the IDLE->ADDR transition. An upstream port dropping awvalid/arvalid after being granted is an AXI violation and is not handled.
- Reset mid-transaction: FSMs return to IDLE the next clock edge and all handshakes deassert. The downstream slave must be reset simultaneously; no draining is attempted.
- Combinational paths: ready/valid muxing is combinational from registered state only. There are no combinational paths between upstream ports other than through the mux select.

Test Plan:
- Single write: s0 issues AW addr 0x100, len=3, 4 W beats (wlast on beat 4), m_axi returns bresp=0. Required: m_axi.awvalid rises 1 cycle after s0.awvalid; all 4 beats forwarded in order; s0 sees bvalid; s1 sees no handshake; wr_busy returns to 0.
- Contention after reset: s0 and s1 both assert awvalid in the same cycle. Required: s0 is served first; s1 is granted immediately after s0's B handshake; wr_grant = 0 then 1.
- Fairness: both ports continuously request reads (len=0), 6 transactions. Required: grants alternate 0,1,0,1,0,1; rd_grant toggles each transaction.
- Concurrent paths: s0 writes while s1 reads, with m_axi backpressure (random ready, 50%). Required: both transactions complete with correct data/resp; the write path holds s0 and the read path holds s1 simultaneously.
- Reset mid-burst: assert rst_n=0 during beat 2 of an 8-beat read to s1. Required: after the edge, all valids/readies = 0, rd_busy = 0; a subsequent s0 read completes normally.
- Early W: s1 presents wvalid 3 cycles before awvalid. Required: s1.wready stays 0 until the AW handshake completes; data is forwarded afterwards without loss.
